// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector front end: default sizes and
// the serializer state type.
package seq_pkg;

  localparam int SEQ_W_DEF     = 8;
  localparam int SEQ_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/seq_fifo.sv
// Generic synchronous circular-buffer FIFO with registered count.
// Head word is presented combinationally on rdata; there is no write-to-read bypass.
module seq_fifo
  import seq_pkg::*;
#(
  parameter int W     = SEQ_W_DEF,
  parameter int DEPTH = SEQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/seq_serializer.sv
// Buffers W-bit words and shifts them out MSB-first, one bit per clock,
// chaining consecutive words with no idle bit between them.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int W     = SEQ_W_DEF,
  parameter int DEPTH = SEQ_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         dout,
  output logic         dout_valid,
  output logic         busy
);

  localparam int BW = $clog2(W);

  ser_state_t               state, state_nxt;
  logic [W-1:0]             shift_reg, shift_nxt;
  logic [BW-1:0]            bit_cnt, bit_cnt_nxt;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic [W-1:0]             fifo_rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count;

  assign fifo_push = in_valid && !fifo_full;

  seq_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
    end
  end

  // On the last bit the next word is reloaded in the same edge so the stream stays gapless.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    fifo_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shift_nxt   = fifo_rdata;
          bit_cnt_nxt = BW'(W - 1);
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            shift_nxt   = fifo_rdata;
            bit_cnt_nxt = BW'(W - 1);
          end else begin
            shift_nxt = {shift_reg[W-2:0], 1'b0};
            state_nxt = IDLE;
          end
        end else begin
          shift_nxt   = {shift_reg[W-2:0], 1'b0};
          bit_cnt_nxt = bit_cnt - BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready   = !fifo_full;
  assign dout_valid = (state == SHIFT);
  assign dout       = (state == SHIFT) && shift_reg[W-1];
  assign busy       = (state == SHIFT) || (fifo_count != '0);

endmodule

// File: tb/tb_seq_serializer.sv
// Directed self-checking bench for seq_serializer: timing of single words,
// gapless chaining, backpressure, idle gaps, mid-word reset and push/pop overlap.
module tb_seq_serializer;
  import seq_pkg::*;

  localparam int W     = SEQ_W_DEF;
  localparam int DEPTH = SEQ_DEPTH_DEF;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         dout;
  logic         dout_valid;
  logic         busy;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  bit mon_bits[$];
  int mon_stamp[$];

  seq_serializer #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid serial bit with the cycle it appeared in, for order and gap checks.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      mon_bits.push_back(dout);
      mon_stamp.push_back(cyc);
    end
  end

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (dout !== 1'b0) $display("[TB] FAIL reset_dout: got %b expected 0", dout); else passes++;
    checks++; if (dout_valid !== 1'b0) $display("[TB] FAIL reset_dout_valid: got %b expected 0", dout_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
  endtask

  task automatic test_single();
    logic [7:0] word = 8'hB0;
    in_valid = 1'b1;
    in_data  = word;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (dout_valid !== 1'b0) $display("[TB] FAIL single_push_cycle_valid: got %b expected 0", dout_valid); else passes++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (dout_valid !== 1'b1) $display("[TB] FAIL single_valid[%0d]: got %b expected 1", i, dout_valid); else passes++;
      checks++; if (dout !== word[7-i]) $display("[TB] FAIL single_bit[%0d]: got %b expected %b", i, dout, word[7-i]); else passes++;
    end
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0) $display("[TB] FAIL single_after_valid: got %b expected 0", dout_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL single_after_busy: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_back_to_back();
    int          base   = mon_bits.size();
    logic [15:0] stream = 16'h0580;
    in_valid = 1'b1;
    in_data  = 8'h05;
    @(negedge clk);
    in_data  = 8'h80;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (mon_bits.size() - base != 16) begin
      $display("[TB] FAIL b2b_bit_count: got %0d expected 16", mon_bits.size() - base);
    end else begin
      passes++;
      for (int i = 0; i < 16; i++) begin
        checks++; if (mon_bits[base+i] != stream[15-i]) $display("[TB] FAIL b2b_bit[%0d]: got %b expected %b", i, mon_bits[base+i], stream[15-i]); else passes++;
      end
      checks++; if (mon_stamp[base+15] - mon_stamp[base] != 15) $display("[TB] FAIL b2b_contiguous: got span %0d expected 15", mon_stamp[base+15] - mon_stamp[base]); else passes++;
    end
  endtask

  task automatic test_fill();
    int         base = mon_bits.size();
    int         idx  = 0;
    logic [7:0] fw [10] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'hCC, 8'h33};
    logic       exp_rdy [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int j = 0; j < 10; j++) begin
      in_valid = 1'b1;
      in_data  = fw[idx];
      checks++; if (in_ready !== exp_rdy[j]) $display("[TB] FAIL fill_in_ready[%0d]: got %b expected %b", j, in_ready, exp_rdy[j]); else passes++;
      @(negedge clk);
      if (exp_rdy[j]) idx++;
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL fill_ready_after_pop: got %b expected 1", in_ready); else passes++;
    repeat (50) @(negedge clk);
    checks++;
    if (mon_bits.size() - base != 40) begin
      $display("[TB] FAIL fill_bit_count: got %0d expected 40", mon_bits.size() - base);
    end else begin
      passes++;
      for (int i = 0; i < 40; i++) begin
        checks++; if (mon_bits[base+i] != fw[i/8][7-(i%8)]) $display("[TB] FAIL fill_bit[%0d]: got %b expected %b", i, mon_bits[base+i], fw[i/8][7-(i%8)]); else passes++;
      end
      checks++; if (mon_stamp[base+39] - mon_stamp[base] != 39) $display("[TB] FAIL fill_contiguous: got span %0d expected 39", mon_stamp[base+39] - mon_stamp[base]); else passes++;
    end
  endtask

  task automatic test_idle_gap();
    int          base   = mon_bits.size();
    logic [15:0] stream = 16'hC33C;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    @(negedge clk);
    in_valid = 1'b0;
    for (int g = 1; g <= 20; g++) begin
      @(negedge clk);
      if (g >= 9) begin
        checks++; if (dout !== 1'b0) $display("[TB] FAIL gap_dout[%0d]: got %b expected 0", g, dout); else passes++;
        checks++; if (dout_valid !== 1'b0) $display("[TB] FAIL gap_valid[%0d]: got %b expected 0", g, dout_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL gap_busy[%0d]: got %b expected 0", g, busy); else passes++;
      end
    end
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (mon_bits.size() - base != 16) begin
      $display("[TB] FAIL gap_bit_count: got %0d expected 16", mon_bits.size() - base);
    end else begin
      passes++;
      for (int i = 0; i < 16; i++) begin
        checks++; if (mon_bits[base+i] != stream[15-i]) $display("[TB] FAIL gap_bit[%0d]: got %b expected %b", i, mon_bits[base+i], stream[15-i]); else passes++;
      end
      checks++; if (mon_stamp[base+8] - mon_stamp[base+7] != 14) $display("[TB] FAIL gap_spacing: got %0d expected 14", mon_stamp[base+8] - mon_stamp[base+7]); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    int         base   = mon_bits.size();
    logic [4:0] prefix = 5'b11100;
    in_valid = 1'b1;
    in_data  = 8'hE7;
    @(negedge clk);
    in_data  = 8'h99;
    @(negedge clk);
    in_data  = 8'h66;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (dout !== 1'b0) $display("[TB] FAIL midrst_dout: got %b expected 0", dout); else passes++;
    checks++; if (dout_valid !== 1'b0) $display("[TB] FAIL midrst_valid: got %b expected 0", dout_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else passes++;
    repeat (25) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy_later: got %b expected 0", busy); else passes++;
    checks++;
    if (mon_bits.size() - base != 5) begin
      $display("[TB] FAIL midrst_bit_count: got %0d expected 5", mon_bits.size() - base);
    end else begin
      passes++;
      for (int i = 0; i < 5; i++) begin
        checks++; if (mon_bits[base+i] != prefix[4-i]) $display("[TB] FAIL midrst_bit[%0d]: got %b expected %b", i, mon_bits[base+i], prefix[4-i]); else passes++;
      end
    end
  endtask

  task automatic test_simul_push_pop();
    int         base = mon_bits.size();
    int         idx  = 0;
    logic       do_push;
    logic [7:0] sw [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    for (int j = 0; j <= 10; j++) begin
      do_push  = (j < 4) || (j >= 9);
      in_valid = do_push;
      in_data  = sw[idx];
      checks++; if (in_ready !== 1'b1) $display("[TB] FAIL simul_in_ready[%0d]: got %b expected 1", j, in_ready); else passes++;
      @(negedge clk);
      if (do_push) idx++;
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL simul_full_after: got %b expected 0", in_ready); else passes++;
    repeat (60) @(negedge clk);
    checks++;
    if (mon_bits.size() - base != 48) begin
      $display("[TB] FAIL simul_bit_count: got %0d expected 48", mon_bits.size() - base);
    end else begin
      passes++;
      for (int i = 0; i < 48; i++) begin
        checks++; if (mon_bits[base+i] != sw[i/8][7-(i%8)]) $display("[TB] FAIL simul_bit[%0d]: got %b expected %b", i, mon_bits[base+i], sw[i/8][7-(i%8)]); else passes++;
      end
      checks++; if (mon_stamp[base+47] - mon_stamp[base] != 47) $display("[TB] FAIL simul_contiguous: got span %0d expected 47", mon_stamp[base+47] - mon_stamp[base]); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_idle_gap();
    test_reset_mid();
    test_simul_push_pop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
